// File: rtl/score_disp_pkg.sv
// Shared types and helpers for the score BCD display block.
//   state_t     : controller states (IDLE, CONVERT, DONE)
//   BCD_W       : bits per BCD digit
//   clog2       : width helper for the iteration counter
//   pri_onehot  : lowest-set-bit one-hot (bit 0 has highest priority)
//   digits_ok   : true when N digits can hold every SCORE_W-bit value
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Isolate the lowest set bit: x & -x. Callers size-cast the result.
    function automatic logic [31:0] pri_onehot(input logic [31:0] sel);
        return sel & (~sel + 32'd1);
    endfunction

    // 10**n_digits >= 2**score_w, with both powers saturated well below
    // the 64-bit limit so large parameters cannot wrap.
    function automatic bit digits_ok(input int score_w, input int n_digits);
        longint unsigned p10;
        longint unsigned p2;
        longint unsigned cap;
        cap = 64'h0100_0000_0000_0000;
        p10 = 1;
        p2  = 1;
        for (int i = 0; i < n_digits; i++) begin
            if (p10 < cap) p10 = p10 * 10;
        end
        for (int i = 0; i < score_w; i++) begin
            if (p2 < cap) p2 = p2 * 2;
        end
        return (p10 >= p2);
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration, purely combinational.
//   acc_in  : current packed BCD accumulator (digit k at [4k +: 4])
//   bin_msb : binary bit shifted into the accumulator LSB this iteration
//   acc_out : accumulator after per-nibble add-3 and a one-bit left shift
module bcd_dd_step
    import score_disp_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic [BCD_W*N_DIGITS-1:0] acc_in,
    input  logic                      bin_msb,
    output logic [BCD_W*N_DIGITS-1:0] acc_out
);

    logic [BCD_W*N_DIGITS-1:0] adj;

    // Nibbles are adjusted independently; a nibble >= 5 becomes <= 12,
    // so no carry ever crosses into the next digit.
    always_comb begin
        adj = acc_in;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (acc_in[BCD_W*k +: BCD_W] >= 4'd5) begin
                adj[BCD_W*k +: BCD_W] = acc_in[BCD_W*k +: BCD_W] + 4'd3;
            end
        end
        acc_out = {adj[BCD_W*N_DIGITS-2:0], bin_msb};
    end

endmodule

// File: rtl/score_bcd_display.sv
// Score-to-BCD display encoder.
// Picks the lowest-index requesting team, converts its binary score to
// packed BCD with a sequential double-dabble engine (one bit per clock) and
// presents digits, team one-hot and a leading-zero blank mask with a
// one-cycle valid pulse.
//   clk, rst    : clock and synchronous active-high reset
//   sel         : per-team request levels, bit 0 highest priority
//   scores      : flat score bus, team i at [i*SCORE_W +: SCORE_W]
//   clear       : synchronous display clear / conversion abort
//   busy        : conversion in flight
//   valid       : one-cycle pulse with new bcd/team_onehot/blank
//   bcd         : packed BCD digits, digit 0 = ones
//   team_onehot : team currently displayed
//   blank       : leading-zero mask, bit 0 always 0
module score_bcd_display
    import score_disp_pkg::*;
#(
    parameter int N_TEAMS    = 3,
    parameter int SCORE_W    = 10,
    parameter int N_DIGITS   = 4,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TEAMS-1:0]        sel,
    input  logic [N_TEAMS*SCORE_W-1:0] scores,
    input  logic                      clear,
    output logic                      busy,
    output logic                      valid,
    output logic [BCD_W*N_DIGITS-1:0] bcd,
    output logic [N_TEAMS-1:0]        team_onehot,
    output logic [N_DIGITS-1:0]       blank
);

    if (!digits_ok(SCORE_W, N_DIGITS)) begin : g_digits_chk
        $fatal(1, "score_bcd_display: N_DIGITS too small for SCORE_W");
    end

    localparam int CNT_W = clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);
    // Idle mask shows a lone '0' in the ones position.
    localparam logic [N_DIGITS-1:0] BLANK_RST =
        BLANK_LEAD ? ~N_DIGITS'(1) : '0;

    function automatic logic [N_DIGITS-1:0] blank_of(
        input logic [BCD_W*N_DIGITS-1:0] d
    );
        logic all_zero;
        blank_of = '0;
        all_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            all_zero    = all_zero & (d[BCD_W*k +: BCD_W] == 4'd0);
            blank_of[k] = all_zero;
        end
    endfunction

    state_t                    state;
    logic [SCORE_W-1:0]        bin_sr;
    logic [BCD_W*N_DIGITS-1:0] acc;
    logic [BCD_W*N_DIGITS-1:0] acc_next;
    logic [CNT_W-1:0]          cnt;
    logic [N_TEAMS-1:0]        pend_team;
    logic [N_TEAMS-1:0]        sel_onehot;
    logic [SCORE_W-1:0]        sel_score;

    assign sel_onehot = N_TEAMS'(pri_onehot(32'(sel)));

    // Walk downward so the lowest requesting index is the one that sticks.
    always_comb begin
        sel_score = '0;
        for (int i = N_TEAMS - 1; i >= 0; i--) begin
            if (sel[i]) sel_score = scores[i*SCORE_W +: SCORE_W];
        end
    end

    bcd_dd_step #(
        .N_DIGITS (N_DIGITS)
    ) u_step (
        .acc_in  (acc),
        .bin_msb (bin_sr[SCORE_W-1]),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk) begin
        valid <= 1'b0;
        if (rst || clear) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bcd         <= '0;
            team_onehot <= '0;
            blank       <= BLANK_RST;
            bin_sr      <= '0;
            acc         <= '0;
            cnt         <= '0;
            pend_team   <= '0;
        end else begin
            case (state)
                // Capture: latch score and team, start the engine.
                IDLE: begin
                    if (|sel) begin
                        bin_sr    <= sel_score;
                        pend_team <= sel_onehot;
                        acc       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                // Iterate: one add-3/shift per edge, SCORE_W edges total.
                CONVERT: begin
                    acc    <= acc_next;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) state <= DONE;
                end
                // Publish: registered outputs plus the valid pulse.
                DONE: begin
                    bcd         <= acc;
                    team_onehot <= pend_team;
                    blank       <= BLANK_LEAD ? blank_of(acc) : '0;
                    valid       <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
module tb_score_bcd_display;

    localparam int N_TEAMS  = 3;
    localparam int SCORE_W  = 10;
    localparam int N_DIGITS = 4;

    logic                         clk;
    logic                         rst;
    logic [N_TEAMS-1:0]           sel;
    logic [N_TEAMS*SCORE_W-1:0]   scores;
    logic                         clear;
    logic                         busy;
    logic                         valid;
    logic [4*N_DIGITS-1:0]        bcd;
    logic [N_TEAMS-1:0]           team_onehot;
    logic [N_DIGITS-1:0]          blank;

    int n_checks;
    int n_fail;

    score_bcd_display #(
        .N_TEAMS    (N_TEAMS),
        .SCORE_W    (SCORE_W),
        .N_DIGITS   (N_DIGITS),
        .BLANK_LEAD (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .scores      (scores),
        .clear       (clear),
        .busy        (busy),
        .valid       (valid),
        .bcd         (bcd),
        .team_onehot (team_onehot),
        .blank       (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_score(input int team, input int value);
        scores[team*SCORE_W +: SCORE_W] = SCORE_W'(value);
    endtask

    // Hold sel across exactly one rising edge (the capture edge); returns
    // at the falling edge just after it.
    task automatic do_request(input logic [N_TEAMS-1:0] s);
        @(negedge clk);
        sel = s;
        @(negedge clk);
        sel = '0;
    endtask

    // Advance falling edges until valid is seen or the budget runs out.
    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got %h want %h", bcd, 16'h0000); end
        n_checks++; if (team_onehot !== 3'b000) begin n_fail++; $display("FAIL reset_team got %b want %b", team_onehot, 3'b000); end
        n_checks++; if (blank !== 4'b1110) begin n_fail++; $display("FAIL reset_blank got %b want %b", blank, 4'b1110); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    endtask

    task automatic test_single();
        int busy_cnt;
        int lat;
        set_score(0, 7);
        do_request(3'b001);
        busy_cnt = 0;
        lat = 1;
        while (valid !== 1'b1 && lat < 30) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        // lat counts the edge whose aftermath shows valid (capture = edge 1).
        n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL single_latency got %0d want 12", lat); end
        n_checks++; if (busy_cnt !== 11) begin n_fail++; $display("FAIL single_busy_cycles got %0d want 11", busy_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_valid got %b want 0", busy); end
        n_checks++; if (bcd !== 16'h0007) begin n_fail++; $display("FAIL single_bcd got %h want %h", bcd, 16'h0007); end
        n_checks++; if (team_onehot !== 3'b001) begin n_fail++; $display("FAIL single_team got %b want %b", team_onehot, 3'b001); end
        n_checks++; if (blank !== 4'b1110) begin n_fail++; $display("FAIL single_blank got %b want %b", blank, 4'b1110); end
        repeat (3) @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_pulse got %b want 0", valid); end
        n_checks++; if (bcd !== 16'h0007) begin n_fail++; $display("FAIL single_hold_bcd got %h want %h", bcd, 16'h0007); end
        n_checks++; if (team_onehot !== 3'b001) begin n_fail++; $display("FAIL single_hold_team got %b want %b", team_onehot, 3'b001); end
    endtask

    task automatic test_priority();
        int n;
        set_score(1, 45);
        set_score(2, 999);
        do_request(3'b110);
        wait_valid(n);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL prio_b_valid got %b want 1 after %0d cycles", valid, n); end
        n_checks++; if (team_onehot !== 3'b010) begin n_fail++; $display("FAIL prio_b_team got %b want %b", team_onehot, 3'b010); end
        n_checks++; if (bcd !== 16'h0045) begin n_fail++; $display("FAIL prio_b_bcd got %h want %h", bcd, 16'h0045); end
        n_checks++; if (blank !== 4'b1100) begin n_fail++; $display("FAIL prio_b_blank got %b want %b", blank, 4'b1100); end
        do_request(3'b100);
        wait_valid(n);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL prio_c_valid got %b want 1 after %0d cycles", valid, n); end
        n_checks++; if (team_onehot !== 3'b100) begin n_fail++; $display("FAIL prio_c_team got %b want %b", team_onehot, 3'b100); end
        n_checks++; if (bcd !== 16'h0999) begin n_fail++; $display("FAIL prio_c_bcd got %h want %h", bcd, 16'h0999); end
        n_checks++; if (blank !== 4'b1000) begin n_fail++; $display("FAIL prio_c_blank got %b want %b", blank, 4'b1000); end
    endtask

    task automatic test_boundaries();
        int          score_v [3] = '{1023, 0, 10};
        logic [15:0] bcd_v   [3] = '{16'h1023, 16'h0000, 16'h0010};
        logic [3:0]  blank_v [3] = '{4'b0000, 4'b1110, 4'b1100};
        int n;
        for (int t = 0; t < 3; t++) begin
            set_score(0, score_v[t]);
            do_request(3'b001);
            wait_valid(n);
            n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bound_%0d_valid got %b want 1", score_v[t], valid); end
            n_checks++; if (bcd !== bcd_v[t]) begin n_fail++; $display("FAIL bound_%0d_bcd got %h want %h", score_v[t], bcd, bcd_v[t]); end
            n_checks++; if (blank !== blank_v[t]) begin n_fail++; $display("FAIL bound_%0d_blank got %b want %b", score_v[t], blank, blank_v[t]); end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses;
        set_score(0, 512);
        do_request(3'b001);
        // now just after edge 1; disturb inputs over edges 3..8
        @(negedge clk);
        sel = 3'b010;
        set_score(0, 3);
        repeat (6) @(negedge clk);
        sel = '0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (valid === 1'b1) begin
                pulses++;
                n_checks++; if (bcd !== 16'h0512) begin n_fail++; $display("FAIL busy_ign_bcd got %h want %h", bcd, 16'h0512); end
                n_checks++; if (team_onehot !== 3'b001) begin n_fail++; $display("FAIL busy_ign_team got %b want %b", team_onehot, 3'b001); end
            end
            @(negedge clk);
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_ign_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_abort(input bit use_rst);
        int pulses;
        set_score(0, 7);
        do_request(3'b001);
        repeat (4) @(negedge clk);
        if (use_rst) rst = 1'b1; else clear = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort%0d_busy got %b want 0", use_rst, busy); end
        n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL abort%0d_bcd got %h want %h", use_rst, bcd, 16'h0000); end
        n_checks++; if (team_onehot !== 3'b000) begin n_fail++; $display("FAIL abort%0d_team got %b want %b", use_rst, team_onehot, 3'b000); end
        n_checks++; if (blank !== 4'b1110) begin n_fail++; $display("FAIL abort%0d_blank got %b want %b", use_rst, blank, 4'b1110); end
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (valid === 1'b1) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort%0d_no_valid got %0d pulses want 0", use_rst, pulses); end
    endtask

    task automatic test_after_abort();
        int n;
        set_score(0, 86);
        do_request(3'b001);
        wait_valid(n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL restart_latency got %0d want 11", n); end
        n_checks++; if (bcd !== 16'h0086) begin n_fail++; $display("FAIL restart_bcd got %h want %h", bcd, 16'h0086); end
        n_checks++; if (team_onehot !== 3'b001) begin n_fail++; $display("FAIL restart_team got %b want %b", team_onehot, 3'b001); end
        n_checks++; if (blank !== 4'b1100) begin n_fail++; $display("FAIL restart_blank got %b want %b", blank, 4'b1100); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        sel      = '0;
        scores   = '0;
        test_reset();
        test_single();
        test_priority();
        test_boundaries();
        test_busy_ignore();
        test_abort(1'b0);
        test_abort(1'b1);
        test_after_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
